// File: rtl/snake_pkg.sv
// Shared constants and enums for the snake game datapaths and the pixel-port arbiter.
package snake_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int CLR_W    = 3;

  localparam logic [CLR_W-1:0] CLR_BLACK = 3'b000;
  localparam logic [CLR_W-1:0] CLR_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    RIGHT,
    UP,
    DOWN,
    LEFT
  } dir_t;

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// Rotating-priority selector: first set request bit above last_grant, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [NUM_REQ-1:0] rot_req;
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];

  // Slot gi holds the requester gi+1 positions after last_grant; one subtract suffices for the wrap.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    localparam logic [IDX_W:0] OFF  = (IDX_W+1)'(gi + 1);
    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);
    logic [IDX_W:0] sum;
    assign sum          = {1'b0, last_grant} + OFF;
    assign rot_idx[gi]  = (sum >= NREQ) ? IDX_W'(sum - NREQ) : sum[IDX_W-1:0];
    assign rot_req[gi]  = req[rot_idx[gi]];
  end

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        valid  = 1'b1;
        winner = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin owner of the VGA pixel-write port: each grant sweeps one BLK_W x BLK_H block, then acks.
module plot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int BLK_W    = 2,
  parameter int BLK_H    = 2,
  parameter int X_W      = snake_pkg::X_W,
  parameter int Y_W      = snake_pkg::Y_W,
  parameter int CLR_W    = snake_pkg::CLR_W,
  parameter int SCREEN_W = snake_pkg::SCREEN_W,
  parameter int SCREEN_H = snake_pkg::SCREEN_H,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*CLR_W-1:0] req_clr,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     plot,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [CLR_W-1:0]         colour
);

  import snake_pkg::*;

  localparam int CNT_W = 2;

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   last_grant_reg;
  logic [IDX_W-1:0]   grant_id_reg;
  logic [X_W-1:0]     base_x_reg;
  logic [Y_W-1:0]     base_y_reg;
  logic [CLR_W-1:0]   clr_reg;
  logic [CNT_W-1:0]   cx_reg, cy_reg;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               cx_last, cy_last;
  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;
  logic               on_screen;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant_reg),
    .valid     (pick_valid),
    .winner    (pick_idx)
  );

  assign cx_last   = (cx_reg == CNT_W'(BLK_W - 1));
  assign cy_last   = (cy_reg == CNT_W'(BLK_H - 1));
  // Clip on the untruncated sums so a block hanging off the right/bottom edge never wraps onto the screen.
  assign x_sum     = {1'b0, base_x_reg} + (X_W+1)'(cx_reg);
  assign y_sum     = {1'b0, base_y_reg} + (Y_W+1)'(cy_reg);
  assign on_screen = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = SWEEP;
      SWEEP:   if (cx_last && cy_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      grant_id_reg   <= '0;
      base_x_reg     <= '0;
      base_y_reg     <= '0;
      clr_reg        <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            base_x_reg   <= req_x[pick_idx*X_W +: X_W];
            base_y_reg   <= req_y[pick_idx*Y_W +: Y_W];
            clr_reg      <= req_clr[pick_idx*CLR_W +: CLR_W];
            grant_id_reg <= pick_idx;
            cx_reg       <= '0;
            cy_reg       <= '0;
          end
        end
        SWEEP: begin
          if (cx_last) begin
            cx_reg <= '0;
            cy_reg <= cy_reg + 1'b1;
          end else begin
            cx_reg <= cx_reg + 1'b1;
          end
        end
        DONE:    last_grant_reg <= grant_id_reg;
        default: ;
      endcase
    end
  end

  always_comb begin
    plot = 1'b0;
    busy = 1'b0;
    ack  = '0;
    case (state_reg)
      SWEEP: begin
        plot = on_screen;
        busy = 1'b1;
      end
      DONE: begin
        busy              = 1'b1;
        ack[grant_id_reg] = 1'b1;
      end
      default: ;
    endcase
  end

  assign x        = x_sum[X_W-1:0];
  assign y        = y_sum[Y_W-1:0];
  assign colour   = clr_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: a transaction-level model predicts pixels and acks, a monitor checks them.
module tb_plot_arbiter;

  localparam int N    = 3;
  localparam int BW   = 2;
  localparam int BH   = 2;
  localparam int XW   = 9;
  localparam int YW   = 8;
  localparam int CW   = 3;
  localparam int IW   = 2;
  localparam int NPIX = BW * BH;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*YW-1:0] req_y = '0;
  logic [N*CW-1:0] req_clr = '0;
  logic [N-1:0]    ack;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic            plot;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;

  plot_arbiter #(
    .NUM_REQ(N), .BLK_W(BW), .BLK_H(BH), .X_W(XW), .Y_W(YW), .CLR_W(CW),
    .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y), .req_clr(req_clr),
    .ack(ack), .busy(busy), .grant_id(grant_id), .plot(plot), .x(x), .y(y), .colour(colour)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {int x; int y; int c; int t;} pix_t;
  typedef struct {int a; int g; int t;} ack_t;
  pix_t pq[$];
  ack_t aq[$];
  pix_t pe;
  ack_t ae;

  int m_last = N - 1;
  int m_free = 0;
  int m_grant = -100;
  int m_w, m_bx, m_by, m_bc, m_px, m_py;

  bit rnd_mode = 1'b0;
  bit sticky[N];
  int ack_cnt[N];
  int ack_time[N];
  int ack_prev[N];

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: when idle and any request is up, the next requester after the last winner owns
  // the port for one block; every on-screen pixel and the ack are stamped with their expected cycle.
  always @(posedge clk) begin
    if (!resetn) begin
      pq.delete();
      aq.delete();
      m_last  = N - 1;
      m_free  = 0;
      m_grant = -100;
    end else if (cyc >= m_free && req != '0) begin
      m_w = -1;
      for (int k = 1; k <= N; k++)
        if (m_w < 0 && req[(m_last + k) % N]) m_w = (m_last + k) % N;
      m_bx = int'(req_x[m_w*XW +: XW]);
      m_by = int'(req_y[m_w*YW +: YW]);
      m_bc = int'(req_clr[m_w*CW +: CW]);
      for (int p = 0; p < NPIX; p++) begin
        m_px = m_bx + p % BW;
        m_py = m_by + p / BW;
        if (m_px < 160 && m_py < 120) pq.push_back('{m_px, m_py, m_bc, cyc + 1 + p});
      end
      aq.push_back('{1 << m_w, m_w, cyc + NPIX + 1});
      m_last  = m_w;
      m_grant = cyc;
      m_free  = cyc + NPIX + 2;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("busy", int'(busy), int'(cyc > m_grant && cyc < m_free));
      if (plot) begin
        if (pq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_plot: got plot=1 at (%0d,%0d) cycle %0d, expected no pixel", x, y, cyc);
        end else begin
          pe = pq.pop_front();
          chk("pix_x", int'(x), pe.x);
          chk("pix_y", int'(y), pe.y);
          chk("pix_colour", int'(colour), pe.c);
          chk("pix_cycle", cyc, pe.t);
        end
      end
      if (ack != '0) begin
        if (aq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got ack=%b cycle %0d, expected none", ack, cyc);
        end else begin
          ae = aq.pop_front();
          chk("ack_vec", int'(ack), ae.a);
          chk("ack_grant_id", int'(grant_id), ae.g);
          chk("ack_cycle", cyc, ae.t);
          $display("[TB] block done: requester %0d acked at cycle %0d", grant_id, cyc);
        end
      end
    end
  end

  task automatic set_req(int i, int bx, int by, int bc);
    req_x[i*XW +: XW]   = XW'(bx);
    req_y[i*YW +: YW]   = YW'(by);
    req_clr[i*CW +: CW] = CW'(bc);
    req[i]              = 1'b1;
  endtask

  // One clock of requester behaviour: drop req on ack (unless sticky), optionally raise random requests.
  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_cnt[i]++;
        ack_prev[i] = ack_time[i];
        ack_time[i] = cyc;
        if (!sticky[i]) req[i] = 1'b0;
      end else if (rnd_mode && !req[i] && $urandom_range(0, 3) == 0) begin
        set_req(i, int'($urandom_range(0, 175)), int'($urandom_range(0, 130)), int'($urandom_range(0, 7)));
      end
    end
  endtask

  task automatic wait_idle(int max_cycles);
    int n = 0;
    while ((req != '0 || busy) && n < max_cycles) begin
      tick();
      n++;
    end
    if (n >= max_cycles) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", max_cycles);
    end
  endtask

  initial begin
    int n;
    int c0;
    for (int i = 0; i < N; i++) begin
      sticky[i]   = 1'b0;
      ack_cnt[i]  = 0;
      ack_time[i] = 0;
      ack_prev[i] = 0;
    end

    repeat (2) @(posedge clk);
    #2;
    chk("rst_plot", int'(plot), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    resetn = 1'b1;

    set_req(0, 64, 60, 7);
    wait_idle(50);

    set_req(0, 20, 30, 1);
    set_req(1, 40, 50, 2);
    set_req(2, 100, 80, 3);
    wait_idle(100);
    set_req(1, 5, 6, 4);
    wait_idle(50);

    set_req(2, 159, 119, 5);
    wait_idle(50);

    set_req(0, 10, 40, 6);
    tick();
    tick();
    req_x[0 +: XW] = XW'(90);
    req[0] = 1'b0;
    wait_idle(50);

    set_req(0, 30, 30, 2);
    tick();
    tick();
    tick();
    resetn = 1'b0;
    #1;
    chk("async_rst_plot", int'(plot), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ack", int'(ack), 0);
    req = '0;
    tick();
    resetn = 1'b1;
    set_req(0, 50, 50, 3);
    set_req(1, 52, 50, 4);
    wait_idle(100);

    sticky[1] = 1'b1;
    c0 = ack_cnt[1];
    set_req(1, 70, 70, 7);
    n = 0;
    while (ack_cnt[1] < c0 + 2 && n < 100) begin
      tick();
      n++;
    end
    sticky[1] = 1'b0;
    req[1] = 1'b0;
    chk("sticky_two_acks", ack_cnt[1] - c0, 2);
    chk("sticky_ack_gap", ack_time[1] - ack_prev[1], NPIX + 2);
    wait_idle(50);

    rnd_mode = 1'b1;
    repeat (400) tick();
    rnd_mode = 1'b0;
    wait_idle(300);
    repeat (3) tick();

    chk("pix_queue_empty", pq.size(), 0);
    chk("ack_queue_empty", aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single pixel-write port of the 160x120 VGA adapter (plot, x, y, colour) between NUM_REQ drawing engines, e.g. snake head draw, tail erase and food draw.
- Each requester asks for one BLK_W x BLK_H filled block at a base coordinate.
- The arbiter grants round-robin, sweeps the block one pixel per cycle, then acknowledges the requester.
- It sits between the game datapaths and the vga_adapter instance and replaces per-FSM draw/erase pixel counters.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- BLK_W, 2, block width in pixels (1..4)
- BLK_H, 2, block height in pixels (1..4)
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- CLR_W, 3, colour width
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are not plotted
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are not plotted

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester draw request, level
- req_x  in  NUM_REQ*X_W  packed base x; requester i occupies bits [i*X_W +: X_W]
- req_y  in  NUM_REQ*Y_W  packed base y
- req_clr  in  NUM_REQ*CLR_W  packed fill colour
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  high in SWEEP and DONE
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grant
- plot  out  1  pixel write enable to the VGA adapter
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  CLR_W  pixel colour

Behaviour:
- Reset (asynchronous, any state, including mid-sweep):
  - state=IDLE, plot=0, x=0, y=0, colour=0, ack=0, busy=0, grant_id=0.
  - Pixel counters cx=cy=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - An interrupted block is abandoned with no ack.
- All outputs are driven from registers or from pure decode of registered state. No input-to-output combinational path.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - req is sampled only in this state.
  - If req != 0, the winner is the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch base_x, base_y, clr and grant_id of the winner; clear cx and cy; go to SWEEP.
  - If req == 0, stay in IDLE.
- SWEEP:
  - Each cycle emits one pixel: x=base_x+cx, y=base_y+cy, colour=clr.
  - Sums are computed X_W+1 and Y_W+1 bits wide, then truncated to X_W and Y_W bits.
  - plot=1 only if base_x+cx < SCREEN_W and base_y+cy < SCREEN_H, compared on the untruncated sums. Clipped pixels still consume their cycle.
  - Order is x-fastest: cx increments; at BLK_W-1, cx returns to 0 and cy increments.
  - On (cx,cy) = (BLK_W-1, BLK_H-1), go to DONE.
- DONE:
  - ack[grant_id]=1 for exactly one cycle; plot=0.
  - last_grant <= grant_id; go to IDLE.
- Timing: a request seen in IDLE at cycle t produces pixels in cycles t+1..t+BLK_W*BLK_H and ack at t+BLK_W*BLK_H+1. The earliest next grant is sampled at t+BLK_W*BLK_H+2.
- Requester contract:
  - Hold req, req_x, req_y, req_clr stable until ack.
  - Deassert req on the edge where ack is seen, otherwise the block is drawn again.
  - Changing the data after grant has no effect, because it is latched in IDLE.
  - Dropping req mid-sweep does not abort the block; ack is still issued.
- Simultaneous requests: round-robin guarantees each requester waits at most NUM_REQ-1 blocks.
- Wrap-around of the round-robin pointer from NUM_REQ-1 to 0 is required.

Decomposition:
- Shared package snake_pkg holds:
  - SCREEN_W, SCREEN_H, X_W, Y_W, CLR_W
  - colour constants CLR_BLACK=3'b000, CLR_WHITE=3'b111
  - the plot_arbiter state enum (IDLE, SWEEP, DONE)
  - the direction enum RIGHT/UP/DOWN/LEFT for reuse by movement logic
- One sub-module, rr_pick:
  - combinational rotating-priority selector
  - inputs: req and last_grant
  - outputs: valid and winner index
  - verified standalone.

Test Plan:
- Reset, then req=3'b001 with (x,y)=(64,60), clr=7 → plot=1 for 4 cycles at (64,60),(65,60),(64,61),(65,61); ack=3'b001 on cycle 5; busy high for cycles 1-5.
- req=3'b111 held, each requester dropping req on its ack → grant order 0,1,2 with acks 6 cycles apart; then req1 alone → granted next.
- Requester 2 at (159,119) → only pixel (159,119) has plot=1; the other three cycles have plot=0; ack still arrives on cycle 5.
- Requester 0 changes req_x from 10 to 90 mid-sweep and drops req → pixels remain at x=10/11; ack[0] is still pulsed.
- resetn low during the 3rd pixel → plot, busy and ack are 0 immediately (asynchronously); no ack follows; the next grant goes to requester 0.
- Requester 1 keeps req high after its ack with no other requests → block redrawn, second ack 6 cycles after the first.
